exmem_skid: RTL
===============

EXMEM_SKID -- requirements
Module: exmem_skid

Interface
REQ-001 Parameter XLEN, default 64, SHALL set the width of the PC, ALU result and store-data fields.
REQ-002 Parameter RD_W, default 5, SHALL set the destination register index width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 flush  in  1  SHALL be a synchronous kill of all held entries.
REQ-006 in_valid  in  1 / in_ready  out  1  SHALL form the upstream (EX) handshake.
REQ-007 in_pc, in_result, in_data  in  XLEN each; in_zero  in  1; in_rd  in  RD_W; in_ctrl  in  5 SHALL form the payload; in_ctrl bit map: [0] Branch, [1] MemWrite, [2] MemRead, [3] MemtoReg, [4] RegWrite.
REQ-008 out_valid  out  1 / out_ready  in  1  SHALL form the downstream (MEM) handshake.
REQ-009 out_pc, out_result, out_data, out_zero, out_rd, out_ctrl  out  widths as inputs  SHALL present the head entry.
REQ-010 occupancy  out  2  SHALL report held entries (0..2).

Function
REQ-011 Block SHALL hold two entries: main (drives outputs) and skid.
REQ-012 Input accepted SHALL be in_valid && in_ready; output consumed SHALL be out_valid && out_ready.
REQ-013 in_ready SHALL equal NOT skid-valid, from a register (no combinational path from out_ready).
REQ-014 Latency empty-to-output SHALL be 1 cycle; full throughput of 1 entry/cycle SHALL be sustained while out_ready=1.
REQ-015 Main empty, accept: payload SHALL load into main.
REQ-016 Main full, consume and accept, skid empty: payload SHALL replace main.
REQ-017 Main full, no consume, accept: payload SHALL load into skid; in_ready low next cycle.
REQ-018 Skid full, consume: skid SHALL move to main, skid becomes empty, in_ready high next cycle.
REQ-019 Main full, consume, no accept, skid empty: main SHALL become empty.
REQ-020 Ordering SHALL be strict FIFO; no entry dropped or duplicated except by flush/reset.
REQ-021 flush SHALL take priority over all transfers: both entries invalid next cycle, same-cycle input discarded, occupancy 0.
REQ-022 When out_valid=0, out_ctrl SHALL be forced to 0; other payload outputs hold last value.
REQ-023 occupancy SHALL equal main-valid + skid-valid, updated same edge as the valid bits.

Reset
REQ-024 On reset low, immediately and mid-transfer: both valids 0, in_ready 1, occupancy 0, all payload outputs 0, out_ctrl 0.
REQ-025 First edge after reset release SHALL accept input normally.

Configuration
REQ-026 Macro EXMEM_SKID_PERF_EN defined: ports stall_cnt out 32 (counts cycles with out_valid && !out_ready) and flush_cnt out 16 (counts flushes that discard at least one valid entry) SHALL exist, both saturating, cleared only by reset.
REQ-027 Macro undefined: those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-028 Empty, out_ready=1, in_valid=1 with in_result=0x1234, in_ctrl=0x11 -> next cycle out_valid=1, out_result=0x1234, out_ctrl=0x11, occupancy=1.
REQ-029 Stream A,B,C with out_ready=0 from cycle 1 -> A in main, B in skid, in_ready=0, C held upstream; out_ready=1 -> outputs A,B,C in order, no gaps.
REQ-030 occupancy=2, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; flush_cnt +1 if PERF_EN.
REQ-031 reset low while occupancy=2 and out_ready toggling -> outputs zero immediately, no edge required.
REQ-032 Random in_valid/out_ready 10000 cycles vs scoreboard -> exact order match, in_ready never low with skid empty.
REQ-033 PERF_EN: out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5; forced to 0xFFFFFFFF -> stays saturated.

Source files
------------

// File: rtl/exmem_skid.sv
// -----------------------------------------------------------------------------
// exmem_skid
//   Two-entry skid buffer sitting between the EX and MEM pipeline stages.
//   The "main" entry drives the outputs; the "skid" entry absorbs the one
//   payload that arrives while the consumer is stalling. in_ready comes
//   straight from a flop, so there is no combinational path from out_ready
//   back to the upstream stage, yet a full one-entry-per-cycle stream is
//   sustained while out_ready stays high.
//
// Ports
//   clk                  single clock, rising edge
//   reset                asynchronous, active-low reset
//   flush                synchronous kill of both held entries (highest priority)
//   in_valid / in_ready  upstream (EX) handshake
//   in_pc, in_result, in_data [XLEN], in_zero, in_rd [RD_W], in_ctrl [5]
//                        payload; in_ctrl = {RegWrite, MemtoReg, MemRead,
//                        MemWrite, Branch} (bit 4 .. bit 0)
//   out_valid / out_ready downstream (MEM) handshake
//   out_*                head entry; out_ctrl reads 0 whenever out_valid is 0,
//                        the other payload outputs keep their last value
//   occupancy [2]        number of held entries, 0..2
//
// Optional build macro
//   EXMEM_SKID_PERF_EN   adds stall_cnt [32] (cycles with out_valid && !out_ready)
//                        and flush_cnt [16] (flushes that killed a valid entry);
//                        both saturate and are cleared only by reset.
// -----------------------------------------------------------------------------
module exmem_skid #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned RD_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_result,
    input  logic [XLEN-1:0] in_data,
    input  logic            in_zero,
    input  logic [RD_W-1:0] in_rd,
    input  logic [4:0]      in_ctrl,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_data,
    output logic            out_zero,
    output logic [RD_W-1:0] out_rd,
    output logic [4:0]      out_ctrl,

    output logic [1:0]      occupancy
`ifdef EXMEM_SKID_PERF_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [15:0]     flush_cnt
`endif
);

    localparam int unsigned CTRL_W  = 5;
    localparam int unsigned OCC_W   = 2;
`ifdef EXMEM_SKID_PERF_EN
    localparam int unsigned STALL_W = 32;
    localparam int unsigned FLUSH_W = 16;
`endif

    // One pipeline entry as held in either slot.
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   result;
        logic [XLEN-1:0]   data;
        logic              zero;
        logic [RD_W-1:0]   rd;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    // State registers
    entry_t            main_q,     main_d;
    entry_t            skid_q,     skid_d;
    logic              main_v_q,   main_v_d;
    logic              skid_v_q,   skid_v_d;
    logic              in_ready_q, in_ready_d;
    logic [OCC_W-1:0]  occ_q,      occ_d;

    // Handshake qualifiers
    logic              accept;
    logic              consume;
    entry_t            in_entry;

    // Pack the incoming payload.
    always_comb begin
        in_entry        = '0;
        in_entry.pc     = in_pc;
        in_entry.result = in_result;
        in_entry.data   = in_data;
        in_entry.zero   = in_zero;
        in_entry.rd     = in_rd;
        in_entry.ctrl   = in_ctrl;
    end

    assign accept  = in_valid && in_ready_q;
    assign consume = main_v_q && out_ready;

    // Next-state logic for both slots.
    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;

        if (flush) begin
            // Kill everything; the same-cycle input is dropped as well.
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (skid_v_q) begin
            // in_ready is low while the skid is full, so nothing is accepted here.
            if (consume) begin
                main_d   = skid_q;
                skid_v_d = 1'b0;
            end
        end else if (main_v_q) begin
            if (consume && accept) begin
                main_d = in_entry;
            end else if (consume) begin
                main_v_d = 1'b0;
            end else if (accept) begin
                skid_d   = in_entry;
                skid_v_d = 1'b1;
            end
        end else if (accept) begin
            main_d   = in_entry;
            main_v_d = 1'b1;
        end

        // Control bits must never leak out of an empty head slot.
        if (!main_v_d) begin
            main_d.ctrl = '0;
        end
    end

    // Registered views of the valid bits.
    always_comb begin
        in_ready_d = !skid_v_d;
        occ_d      = OCC_W'(main_v_d) + OCC_W'(skid_v_d);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_v_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            in_ready_q <= 1'b1;
            occ_q      <= '0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_v_q   <= main_v_d;
            skid_v_q   <= skid_v_d;
            in_ready_q <= in_ready_d;
            occ_q      <= occ_d;
        end
    end

    // Outputs are taken directly from flops.
    assign in_ready   = in_ready_q;
    assign out_valid  = main_v_q;
    assign out_pc     = main_q.pc;
    assign out_result = main_q.result;
    assign out_data   = main_q.data;
    assign out_zero   = main_q.zero;
    assign out_rd     = main_q.rd;
    assign out_ctrl   = main_q.ctrl;
    assign occupancy  = occ_q;

`ifdef EXMEM_SKID_PERF_EN
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [FLUSH_W-1:0] flush_q, flush_d;

    // Saturating performance counters.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (main_v_q && !out_ready && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + STALL_W'(1);
        end
        if (flush && (main_v_q || skid_v_q) && (flush_q != {FLUSH_W{1'b1}})) begin
            flush_d = flush_q + FLUSH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`endif

endmodule
